// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - request/response bundle between the execute stage and the multiply/divide unit
//
// Purpose: groups the launch, flush and completion signals of the M-extension unit.
// Ports (master = pipeline side, slave = muldiv_unit side):
//   start      master->slave  launch an op (taken only while busy is low)
//   funct3     master->slave  op select: MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
//   operand_a  master->slave  rs1 value (multiplicand / dividend)
//   operand_b  master->slave  rs2 value (multiplier / divisor)
//   rd_in      master->slave  destination register tag
//   flush      master->slave  abort the in-flight op
//   busy       slave->master  op in flight, stall request
//   done       slave->master  one-cycle completion pulse
//   result     slave->master  op result, held until the next completion
//   rd_out     slave->master  tag of the completed op, held with result
interface muldiv_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             start;
  logic [2:0]       funct3;
  logic [XLEN-1:0]  operand_a;
  logic [XLEN-1:0]  operand_b;
  logic [TAG_W-1:0] rd_in;
  logic             flush;
  logic             busy;
  logic             done;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] rd_out;

  modport master (
    output start, funct3, operand_a, operand_b, rd_in, flush,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, funct3, operand_a, operand_b, rd_in, flush,
    output busy, done, result, rd_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV-M multiply/divide unit, one shift-add/shift-subtract step per cycle
//
// Purpose: executes the eight M-extension ops on operand magnitudes, one iteration per
// clock, then sign-corrects and presents the result with a one-cycle done pulse.
// Divide-by-zero and signed overflow finish immediately without iterating.
// Ports:
//   clk    in  clock, all state updates on the rising edge
//   reset  in  synchronous active-high reset (wins over flush and start)
//   bus    muldiv_if.slave: start/funct3/operand_a/operand_b/rd_in/flush in,
//          busy/done/result/rd_out out
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  localparam int CNT_W = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // Shared working register: multiply {partial product hi, multiplier lo},
  // divide {partial remainder hi, dividend/quotient lo}.
  logic [2*XLEN-1:0]  acc_q, acc_d;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [XLEN-1:0]    opnd_q, opnd_d;
  logic [2:0]         funct3_q, funct3_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [XLEN-1:0]    result_q, result_d;
  logic [TAG_W-1:0]   rd_q, rd_d;

  // ---------------- launch-time operand decode ----------------
  logic              is_div;
  logic              a_signed, b_signed;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              b_zero, sgn_ovf, fast;
  logic [XLEN-1:0]   fast_result;

  always_comb begin
    is_div   = bus.funct3[2];
    // Signed A: MUL, MULH, MULHSU, DIV, REM. Signed B: MUL, MULH, DIV, REM.
    a_signed = is_div ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
    b_signed = is_div ? ~bus.funct3[0] : ~bus.funct3[1];
    a_neg    = a_signed & bus.operand_a[XLEN-1];
    b_neg    = b_signed & bus.operand_b[XLEN-1];
    // MIN_INT negates to itself, which is its correct unsigned magnitude.
    a_mag    = a_neg ? -bus.operand_a : bus.operand_a;
    b_mag    = b_neg ? -bus.operand_b : bus.operand_b;
    b_zero   = (bus.operand_b == '0);
    sgn_ovf  = (bus.operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.operand_b == '1);
    fast     = is_div && (b_zero || (~bus.funct3[0] && sgn_ovf));
    // funct3[1] separates REM/REMU from DIV/DIVU.
    if (b_zero) begin
      fast_result = bus.funct3[1] ? bus.operand_a : '1;
    end else begin
      fast_result = bus.funct3[1] ? '0 : bus.operand_a;
    end
  end

  // ---------------- one iteration ----------------
  logic [XLEN:0]      mul_sum;
  logic [2*XLEN-1:0]  mul_next;
  logic [XLEN:0]      div_shift, div_diff;
  logic [2*XLEN-1:0]  div_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    // The carry out of the add becomes the new top bit after the right shift.
    mul_next = {mul_sum, acc_q[XLEN-1:1]};

    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    // A borrow (top bit set) means the trial subtraction failed: restore.
    if (!div_diff[XLEN]) begin
      div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      div_next = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end
  end

  // ---------------- sign correction ----------------
  logic [2*XLEN-1:0]  prod_fix;
  logic [XLEN-1:0]    quo_fix, rem_fix;
  logic [XLEN-1:0]    final_result;

  always_comb begin
    prod_fix = neg_res_q ? -acc_q : acc_q;
    quo_fix  = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (!funct3_q[2]) begin
      final_result = (funct3_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end else begin
      final_result = funct3_q[1] ? rem_fix : quo_fix;
    end
  end

  // ---------------- FSM next state ----------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    funct3_d  = funct3_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    tag_d     = tag_q;
    result_d  = result_q;
    rd_d      = rd_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          funct3_d = bus.funct3;
          tag_d    = bus.rd_in;
          if (fast) begin
            result_d = fast_result;
            rd_d     = bus.rd_in;
            state_d  = S_DONE;
          end else begin
            acc_d     = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
            opnd_d    = is_div ? b_mag : a_mag;
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            cnt_d     = '0;
            state_d   = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (bus.flush) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(XLEN)) begin
          // All XLEN iterations are in; this edge only finalizes.
          result_d = final_result;
          rd_d     = tag_q;
          cnt_d    = '0;
          state_d  = S_DONE;
        end else begin
          acc_d = funct3_q[2] ? div_next : mul_next;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------- state registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      funct3_q  <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      tag_q     <= '0;
      result_q  <= '0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      funct3_q  <= funct3_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      tag_q     <= tag_d;
      result_q  <= result_d;
      rd_q      <= rd_d;
    end
  end

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = result_q;
  assign bus.rd_out = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit at XLEN=32 and XLEN=8
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_if #(.XLEN(32), .TAG_W(5)) b32 ();
  muldiv_if #(.XLEN(8),  .TAG_W(5)) b8 ();

  muldiv_unit #(.XLEN(32), .TAG_W(5)) dut32 (.clk(clk), .reset(reset), .bus(b32));
  muldiv_unit #(.XLEN(8),  .TAG_W(5)) dut8  (.clk(clk), .reset(reset), .bus(b8));

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  // ---------------- reference arithmetic ----------------
  function automatic longint sx(int w, logic [63:0] v);
    longint s;
    s = longint'(v);
    if (v[w-1]) s = s - (longint'(1) << w);
    return s;
  endfunction

  function automatic bit model_fast(int w, logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    logic [63:0] mask;
    logic [63:0] ua, ub;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    if (!f3[2]) return 1'b0;
    if (ub == 0) return 1'b1;
    return !f3[0] && sx(w, ua) == -(longint'(1) << (w - 1)) && sx(w, ub) == -1;
  endfunction

  function automatic logic [31:0] model_op(int w, logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    logic [63:0] mask, ua, ub, up, r;
    longint sa, sb, p;
    bit ovf;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    sa = sx(w, ua);
    sb = sx(w, ub);
    ovf = (sa == -(longint'(1) << (w - 1))) && (sb == -1);
    case (f3)
      3'd0: begin p = sa * sb; r = 64'(p) & mask; end
      3'd1: begin p = sa * sb; r = 64'(p >>> w) & mask; end
      3'd2: begin p = sa * longint'(ub); r = 64'(p >>> w) & mask; end
      3'd3: begin up = ua * ub; r = (up >> w) & mask; end
      3'd4: r = (ub == 0) ? mask : ovf ? ua : (64'(sa / sb) & mask);
      3'd5: r = (ub == 0) ? mask : ua / ub;
      3'd6: r = (ub == 0) ? ua : ovf ? 64'd0 : (64'(sa % sb) & mask);
      default: r = (ub == 0) ? ua : ua % ub;
    endcase
    return r[31:0];
  endfunction

  // ---------------- cycle-level expectation ----------------
  // lat = edges still to go before the completion cycle; lat==0 while in flight is the done cycle.
  typedef struct {
    bit          inflight;
    int          lat;
    logic [31:0] pend;
    logic [4:0]  prd;
    logic [31:0] res;
    logic [4:0]  rd;
  } mst_t;

  mst_t m32, m8;

  function automatic mst_t mstep(mst_t s, int w, bit rst, bit st, bit fl,
                                 logic [2:0] f3, logic [31:0] a, logic [31:0] b, logic [4:0] rd);
    mst_t n;
    n = s;
    if (rst) begin
      n.inflight = 1'b0; n.lat = 0; n.res = '0; n.rd = '0;
    end else if (s.inflight) begin
      if (fl || s.lat == 0) begin
        n.inflight = 1'b0;
      end else begin
        n.lat = s.lat - 1;
        if (n.lat == 0) begin n.res = s.pend; n.rd = s.prd; end
      end
    end else if (st && !fl) begin
      n.inflight = 1'b1;
      n.pend = model_op(w, f3, a, b);
      n.prd = rd;
      if (model_fast(w, f3, a, b)) begin
        n.lat = 0; n.res = n.pend; n.rd = rd;
      end else begin
        n.lat = w + 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m32 <= mstep(m32, 32, reset, b32.start, b32.flush, b32.funct3,
                 b32.operand_a, b32.operand_b, b32.rd_in);
    m8  <= mstep(m8, 8, reset, b8.start, b8.flush, b8.funct3,
                 {24'd0, b8.operand_a}, {24'd0, b8.operand_b}, b8.rd_in);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy32",   b32.busy,   m32.inflight);
      chk("done32",   b32.done,   m32.inflight && m32.lat == 0);
      chk("result32", b32.result, m32.res);
      chk("rd32",     b32.rd_out, m32.rd);
      chk("busy8",    b8.busy,    m8.inflight);
      chk("done8",    b8.done,    m8.inflight && m8.lat == 0);
      chk("result8",  b8.result,  m8.res[7:0]);
      chk("rd8",      b8.rd_out,  m8.rd);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic run32(string name, logic [2:0] f3, logic [31:0] a, logic [31:0] b, logic [4:0] rd,
                       logic [31:0] exp_res, int exp_edge, output int busy_cycles);
    bit got;
    int n;
    got = 1'b0; n = 0; busy_cycles = 0;
    b32.start = 1'b1; b32.funct3 = f3; b32.operand_a = a; b32.operand_b = b; b32.rd_in = rd;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      b32.start = 1'b0;
      if (b32.busy && !b32.done) busy_cycles++;
      if (b32.done) begin got = 1'b1; n = i; break; end
    end
    chk({name, "_done_seen"}, got, 1);
    if (got) begin
      chk({name, "_result"}, b32.result, exp_res);
      chk({name, "_rd"}, b32.rd_out, rd);
      chk({name, "_edge"}, n - 1, exp_edge);
    end
    @(negedge clk);
  endtask

  task automatic run8(string name, logic [2:0] f3, logic [7:0] a, logic [7:0] b, logic [4:0] rd,
                      logic [7:0] exp_res, int exp_edge);
    bit got;
    int n;
    got = 1'b0; n = 0;
    b8.start = 1'b1; b8.funct3 = f3; b8.operand_a = a; b8.operand_b = b; b8.rd_in = rd;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      b8.start = 1'b0;
      if (b8.done) begin got = 1'b1; n = i; break; end
    end
    chk({name, "_done_seen"}, got, 1);
    if (got) begin
      chk({name, "_result"}, b8.result, exp_res);
      chk({name, "_edge"}, n - 1, exp_edge);
    end
    @(negedge clk);
  endtask

  initial begin
    int nb;
    logic [2:0] rf3;
    logic [31:0] ra, rb;

    reset = 1'b1;
    b32.start = 0; b32.funct3 = 0; b32.operand_a = 0; b32.operand_b = 0; b32.rd_in = 0; b32.flush = 0;
    b8.start = 0;  b8.funct3 = 0;  b8.operand_a = 0;  b8.operand_b = 0;  b8.rd_in = 0;  b8.flush = 0;
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", b32.busy, 0);
    chk("rst_done", b32.done, 0);
    chk("rst_result", b32.result, 0);
    chk("rst_rd", b32.rd_out, 0);
    reset = 1'b0;
    @(negedge clk);

    run32("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, 33, nb);
    chk("mul_busy_run_cycles", nb, 33);
    run32("mulh",   3'd1, 32'h80000000, 32'h80000000, 5'd2, 32'h40000000, 33, nb);
    run32("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2,        5'd3, 32'hFFFFFFFF, 33, nb);
    run32("mulhu",  3'd3, 32'hFFFFFFFF, 32'd2,        5'd4, 32'h00000001, 33, nb);
    run32("div",    3'd4, 32'hFFFFFFF9, 32'd2,        5'd5, 32'hFFFFFFFD, 33, nb);
    run32("rem",    3'd6, 32'hFFFFFFF9, 32'd2,        5'd6, 32'hFFFFFFFF, 33, nb);
    run32("divu",   3'd5, 32'd100,      32'd7,        5'd7, 32'd14,       33, nb);
    run32("div_z",  3'd4, 32'd5,        32'd0,        5'd8, 32'hFFFFFFFF, 0,  nb);
    run32("rem_z",  3'd6, 32'd5,        32'd0,        5'd9, 32'd5,        0,  nb);
    run32("div_ov", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h80000000, 0, nb);
    run32("rem_ov", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'd0,       0,  nb);
    run32("divu_z", 3'd5, 32'd5,        32'd0,        5'd12, 32'hFFFFFFFF, 0, nb);
    run32("remu_z", 3'd7, 32'd5,        32'd0,        5'd13, 32'd5,       0,  nb);
    run32("remu",   3'd7, 32'd100,      32'd7,        5'd14, 32'd2,       33, nb);

    // Flush at RUN iteration 10: no done, idle next cycle, result/rd kept.
    b32.start = 1'b1; b32.funct3 = 3'd0; b32.operand_a = 32'd3; b32.operand_b = 32'd5; b32.rd_in = 5'd20;
    @(negedge clk);
    b32.start = 1'b0;
    repeat (10) @(negedge clk);
    b32.flush = 1'b1;
    @(negedge clk);
    b32.flush = 1'b0;
    chk("flush_busy", b32.busy, 0);
    chk("flush_done", b32.done, 0);
    chk("flush_result", b32.result, 32'd2);
    chk("flush_rd", b32.rd_out, 5'd14);
    run32("after_flush", 3'd0, 32'd3, 32'd5, 5'd21, 32'd15, 33, nb);

    // Flush together with start in idle drops the start.
    b32.start = 1'b1; b32.flush = 1'b1;
    @(negedge clk);
    b32.start = 1'b0; b32.flush = 1'b0;
    chk("flush_start_idle", b32.busy, 0);

    // Start held high: re-issues during run and done are ignored.
    b32.start = 1'b1; b32.funct3 = 3'd0; b32.operand_a = 32'd2; b32.operand_b = 32'd3; b32.rd_in = 5'd22;
    repeat (40) @(negedge clk);
    b32.start = 1'b0;
    repeat (40) @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (k == 2) ? 32'd0 : $urandom;
      run32("rand", rf3, ra, rb, 5'(k), model_op(32, rf3, ra, rb),
            model_fast(32, rf3, ra, rb) ? 0 : 33, nb);
    end

    // Reset mid-op clears everything without a done pulse.
    b32.start = 1'b1; b32.funct3 = 3'd5; b32.operand_a = 32'd1000; b32.operand_b = 32'd3; b32.rd_in = 5'd30;
    @(negedge clk);
    b32.start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstmid_busy", b32.busy, 0);
    chk("rstmid_done", b32.done, 0);
    chk("rstmid_result", b32.result, 0);
    chk("rstmid_rd", b32.rd_out, 0);
    @(negedge clk);

    run8("mulhu8", 3'd3, 8'hFF, 8'hFF, 5'd3, 8'hFE, 9);
    run8("mul8",   3'd0, 8'h0D, 8'hFB, 5'd4, 8'hBF, 9);
    run8("rem8_z", 3'd6, 8'h85, 8'h00, 5'd5, 8'h85, 0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
